// File: rtl/mem_port_arbiter.sv
//------------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory port between instruction fetch and load/store traffic.
//   Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              timeout_err
);

  localparam int c_SW = $clog2(MAX_D_STREAK + 1);
  localparam int c_TW = $clog2(TIMEOUT + 2);
  localparam logic [c_SW-1:0] c_SMAX = c_SW'(MAX_D_STREAK);
  localparam logic [c_TW-1:0] c_TLIM = c_TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_ISSUE = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_sel_d;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic [c_SW-1:0]   r_streak;
  logic [c_TW-1:0]   r_tcnt;
  logic              r_timeout_err;
  logic              w_any_req;
  logic              w_grant_d;
  logic              w_timeout;

  assign w_any_req = i_req | d_req;
  // Data wins a collision until it has starved a waiting fetch for MAX_D_STREAK grants.
  assign w_grant_d = d_req & ~(i_req & (r_streak == c_SMAX));
  assign w_timeout = (TIMEOUT != 0) && (r_tcnt == c_TLIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE:  if (w_any_req) w_next_state = c_ISSUE;
      c_ISSUE: if (mem_ready || w_timeout) w_next_state = c_DONE;
      c_DONE:  w_next_state = c_IDLE;
      default: w_next_state = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_d       <= 1'b0;
      r_addr        <= '0;
      r_we          <= 1'b0;
      r_wdata       <= '0;
      r_i_rdata     <= '0;
      r_d_rdata     <= '0;
      r_streak      <= '0;
      r_tcnt        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            r_sel_d <= w_grant_d;
            if (w_grant_d) begin
              r_addr  <= d_addr;
              r_we    <= d_we;
              r_wdata <= d_wdata;
              if (!i_req) begin
                r_streak <= '0;
              end else if (r_streak != c_SMAX) begin
                r_streak <= r_streak + c_SW'(1);
              end
            end else begin
              r_addr   <= i_addr;
              r_we     <= 1'b0;
              r_wdata  <= '0;
              r_streak <= '0;
            end
          end
        end
        c_ISSUE: begin
          if (mem_ready) begin
            if (r_sel_d) r_d_rdata <= mem_rdata;
            else         r_i_rdata <= mem_rdata;
          end else if (w_timeout) begin
            if (r_sel_d) r_d_rdata <= '0;
            else         r_i_rdata <= '0;
            r_timeout_err <= 1'b1;
          end else begin
            r_tcnt <= r_tcnt + c_TW'(1);
          end
        end
        c_DONE: begin
          r_tcnt <= '0;
        end
        default: begin
          r_tcnt <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    busy      = (r_state != c_IDLE);
    case (r_state)
      c_ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = r_we;
        mem_addr  = r_addr;
        mem_wdata = r_wdata;
      end
      c_DONE: begin
        i_ack = ~r_sel_d;
        d_ack = r_sel_d;
      end
      default: begin
        mem_req = 1'b0;
      end
    endcase
  end

  assign i_rdata     = r_i_rdata;
  assign d_rdata     = r_d_rdata;
  assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//------------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Directed and randomized self-checking bench for mem_port_arbiter.
//   Revision: 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAXS = 4;
  localparam int TO   = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          i_req = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          i_ack;
  logic [DW-1:0] i_rdata;
  logic          d_req = 1'b0;
  logic          d_we = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) cyc();
    reset_n = 1'b1;
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10010010; d_wdata = 32'h00000055;
    cyc(); cyc();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_pre_issue: got %b expected 1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({i_ack, i_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mem_req=%b mem_addr=%h mem_wdata=%h busy=%b expected all 0",
               mem_req, mem_addr, mem_wdata, busy);
    end
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    cyc();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      checks++;
      if ({busy, mem_req} !== 2'b00) begin errors++; $display("FAIL reset_idle: got busy/mem_req=%b expected 00", {busy, mem_req}); end
    end
  endtask

  task automatic test_single_fetch();
    i_req = 1'b1; i_addr = 32'h00400000;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      checks++;
      if ({mem_req, mem_we, i_ack} !== 3'b100 || mem_addr !== 32'h00400000) begin
        errors++;
        $display("FAIL fetch_issue c%0d: got req/we/ack=%b addr=%h expected 100 00400000", c, {mem_req, mem_we, i_ack}, mem_addr);
      end
      if (c == 3) begin mem_ready = 1'b1; mem_rdata = 32'h20080005; end
    end
    cyc();
    checks++;
    if ({i_ack, d_ack, mem_req} !== 3'b100 || i_rdata !== 32'h20080005) begin
      errors++;
      $display("FAIL fetch_ack: got ack_i/ack_d/req=%b rdata=%h expected 100 20080005", {i_ack, d_ack, mem_req}, i_rdata);
    end
    i_req = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    cyc();
    checks++;
    if ({busy, i_ack} !== 2'b00 || i_rdata !== 32'h20080005) begin
      errors++;
      $display("FAIL fetch_after: got busy/ack=%b rdata=%h expected 00 20080005", {busy, i_ack}, i_rdata);
    end
  endtask

  task automatic test_collision();
    i_req = 1'b1; i_addr = 32'h00400004;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010000; d_wdata = 32'h0;
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h10010000 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL coll_data_first: got req=%b addr=%h we=%b expected 1 10010000 0", mem_req, mem_addr, mem_we);
    end
    mem_ready = 1'b1; mem_rdata = 32'h8C880000;
    cyc();
    checks++;
    if ({d_ack, i_ack} !== 2'b10 || d_rdata !== 32'h8C880000) begin
      errors++;
      $display("FAIL coll_d_ack: got d/i ack=%b rdata=%h expected 10 8c880000", {d_ack, i_ack}, d_rdata);
    end
    d_req = 1'b0; mem_ready = 1'b0;
    cyc();
    checks++;
    if ({mem_req, busy} !== 2'b00) begin errors++; $display("FAIL coll_gap: got req/busy=%b expected 00", {mem_req, busy}); end
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h00400004) begin
      errors++;
      $display("FAIL coll_fetch_issue: got req=%b addr=%h expected 1 00400004", mem_req, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = 32'h3C011001;
    cyc();
    checks++;
    if ({i_ack, d_ack} !== 2'b10 || i_rdata !== 32'h3C011001) begin
      errors++;
      $display("FAIL coll_i_ack: got i/d ack=%b rdata=%h expected 10 3c011001", {i_ack, d_ack}, i_rdata);
    end
    i_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  task automatic test_starvation();
    int seq [6];
    int exp_seq [6];
    int n = 0;
    exp_seq = '{1, 1, 1, 1, 0, 1};
    seq = '{-1, -1, -1, -1, -1, -1};
    i_req = 1'b1; i_addr = 32'h00400008;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10010020;
    for (int c = 0; c < 60 && n < 6; c++) begin
      cyc();
      if (i_ack && d_ack) begin
        checks++; errors++;
        $display("FAIL starve_dual_ack: got both acks expected one");
      end
      if (d_ack) begin seq[n] = 1; n++; end
      else if (i_ack) begin seq[n] = 0; n++; end
      mem_ready = mem_req;
      mem_rdata = 32'hA000 + DW'(c);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
    checks++;
    if (n !== 6) begin errors++; $display("FAIL starve_count: got %0d acks expected 6", n); end
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (seq[k] !== exp_seq[k]) begin
        errors++;
        $display("FAIL starve_order[%0d]: got %0d expected %0d (1=data 0=fetch)", k, seq[k], exp_seq[k]);
      end
    end
    cyc();
  endtask

  task automatic test_timeout();
    checks++;
    if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_pre: got %b expected 0", timeout_err); end
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10010008; d_wdata = 32'hCAFEF00D; mem_ready = 1'b0;
    for (int c = 1; c <= TO; c++) begin
      cyc();
      checks++;
      if ({mem_req, mem_we, d_ack, timeout_err} !== 4'b1100 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h10010008) begin
        errors++;
        $display("FAIL to_issue c%0d: got req/we/ack/err=%b wdata=%h addr=%h expected 1100 cafef00d 10010008",
                 c, {mem_req, mem_we, d_ack, timeout_err}, mem_wdata, mem_addr);
      end
    end
    cyc();
    checks++;
    if ({mem_req, d_ack, i_ack, timeout_err} !== 4'b0101 || d_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_done: got req/d_ack/i_ack/err=%b rdata=%h expected 0101 00000000",
               {mem_req, d_ack, i_ack, timeout_err}, d_rdata);
    end
    d_req = 1'b0; d_we = 1'b0;
    repeat (3) begin
      cyc();
      checks++;
      if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    end
  endtask

  task automatic test_reset_mid();
    i_req = 1'b1; i_addr = 32'h00400010;
    cyc();
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rmid_issue: got %b expected 1", mem_req); end
    #1 reset_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD0001;
    #1;
    checks++;
    if ({mem_req, busy, timeout_err, i_ack} !== 4'b0000) begin
      errors++;
      $display("FAIL rmid_drop: got req/busy/err/ack=%b expected 0000", {mem_req, busy, timeout_err, i_ack});
    end
    cyc();
    reset_n = 1'b1;
    cyc();
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h00400010 || i_ack !== 1'b0) begin
      errors++;
      $display("FAIL rmid_regrant: got req=%b addr=%h ack=%b expected 1 00400010 0", mem_req, mem_addr, i_ack);
    end
    mem_ready = 1'b0;
    cyc();
    checks++;
    if ({mem_req, i_ack} !== 2'b10) begin errors++; $display("FAIL rmid_hold: got req/ack=%b expected 10", {mem_req, i_ack}); end
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    cyc();
    checks++;
    if (i_ack !== 1'b1 || i_rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL rmid_ack: got ack=%b rdata=%h expected 1 12345678", i_ack, i_rdata);
    end
    i_req = 1'b0; mem_ready = 1'b0;
    cyc();
  endtask

  // Transaction-level reference: requesters hold a pending access until acked,
  // memory answers after a random latency, grants follow the streak rule.
  task automatic test_random(int ncyc);
    int ph = 0, cnt = 0, lat = 0, streak = 0, c = 0, r;
    logic gd = 1'b0, terr = 1'b0, ip = 1'b0, dp = 1'b0, dwe = 1'b0, e_we = 1'b0;
    logic [31:0] ia = '0, da = '0, dw = '0, e_addr = '0, e_wdata = '0, ack_data = '0;
    while (c < ncyc + 300 && (c < ncyc || ip || dp || ph != 0)) begin
      cyc();
      c++;
      checks++;
      if (timeout_err !== terr) begin errors++; $display("FAIL rnd_terr c%0d: got %b expected %b", c, timeout_err, terr); end
      checks++;
      if (busy !== (ph != 0)) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected %b", c, busy, ph != 0); end
      if (ph == 2) begin
        checks++;
        if ({i_ack, d_ack, mem_req} !== {~gd, gd, 1'b0} || (gd ? d_rdata : i_rdata) !== ack_data) begin
          errors++;
          $display("FAIL rnd_ack c%0d: got i/d/req=%b i_rdata=%h d_rdata=%h expected %b data %h",
                   c, {i_ack, d_ack, mem_req}, i_rdata, d_rdata, {~gd, gd, 1'b0}, ack_data);
        end
      end else begin
        checks++;
        if ({i_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL rnd_spurious_ack c%0d: got %b expected 00", c, {i_ack, d_ack}); end
      end
      if (ph == 1) begin
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== e_addr || mem_we !== e_we || mem_wdata !== e_wdata) begin
          errors++;
          $display("FAIL rnd_issue c%0d: got req=%b addr=%h we=%b wdata=%h expected 1 %h %b %h",
                   c, mem_req, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wdata);
        end
      end else begin
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_low c%0d: got %b expected 0", c, mem_req); end
      end

      if (ph == 2) begin
        if (gd) dp = 1'b0; else ip = 1'b0;
      end else if (c < ncyc) begin
        if (!ip && $urandom_range(0, 2) == 0) begin ip = 1'b1; ia = $urandom; end
        if (!dp && $urandom_range(0, 2) == 0) begin
          dp = 1'b1; da = $urandom; dw = $urandom; dwe = 1'($urandom_range(0, 1));
        end
      end
      i_req = ip; i_addr = ia;
      d_req = dp; d_addr = da; d_wdata = dw; d_we = dwe;
      mem_ready = 1'($urandom_range(0, 1)); mem_rdata = $urandom;

      case (ph)
        0: if (ip || dp) begin
          gd = (ip && dp) ? (streak < MAXS) : dp;
          if (gd) begin
            e_addr = da; e_we = dwe; e_wdata = dw;
            streak = ip ? ((streak < MAXS) ? streak + 1 : MAXS) : 0;
          end else begin
            e_addr = ia; e_we = 1'b0; e_wdata = '0;
            streak = 0;
          end
          r = int'($urandom_range(0, 19));
          lat = (r < 14) ? (r % 4) : ((r < 17) ? TO - 1 : TO + 1);
          cnt = 0;
          ph = 1;
        end
        1: begin
          if (gd) begin d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1)); end
          else i_addr = $urandom;
          if (cnt == lat) begin
            mem_ready = 1'b1; ack_data = mem_rdata; ph = 2;
          end else if (cnt == TO - 1) begin
            mem_ready = 1'b0; ack_data = '0; terr = 1'b1; ph = 2;
          end else begin
            mem_ready = 1'b0; cnt++;
          end
        end
        default: ph = 0;
      endcase
    end
    checks++;
    if (ip || dp || ph != 0) begin
      errors++;
      $display("FAIL rnd_drain: got pending i=%b d=%b phase=%0d expected idle within budget", ip, dp, ph);
    end
    i_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_timeout();
    test_reset_mid();
    test_random(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time budget");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the instruction-fetch path and the load/store data path of the processor. The arbiter accepts one request at a time from each side and issues it to memory. Memory has variable latency, so the arbiter holds each transaction until memory responds, then returns the read data with a one-cycle acknowledge. It sits between the PC/fetch logic, the data-memory interface driven by the `mem_write` / `mem_to_reg` decode signals, and the external memory model.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `MAX_D_STREAK`, 4, maximum consecutive data grants while a fetch is pending (≥1).
- `TIMEOUT`, 255, maximum number of cycles in ISSUE before the transaction is forcibly completed (0 = disabled).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_ack`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_ack`  out  1  one-cycle pulse: fetch complete.
- `i_rdata`  out  DATA_W  fetched word; valid while `i_ack`=1.
- `d_req`  in  1  data request; held until `d_ack`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  store data.
- `d_ack`  out  1  one-cycle pulse: data access complete.
- `d_rdata`  out  DATA_W  load data; valid while `d_ack`=1.
- `mem_req`  out  1  memory transaction active.
- `mem_we`  out  1  write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; sampled when `mem_ready`=1.
- `mem_ready`  in  1  memory completion strobe.
- `busy`  out  1  state ≠ IDLE.
- `timeout_err`  out  1  sticky flag, set on any timeout; cleared only by reset.

## Operation
- State machine has three states: IDLE, ISSUE and DONE. Reset state is IDLE.
- Reset values: every output is 0, the streak counter is 0 and the timeout counter is 0. Reset forces this immediately (asynchronously), including in the middle of a transaction. `mem_req` drops with no handshake.
- IDLE: the arbiter samples `i_req` and `d_req`.
  - Neither is asserted: stay in IDLE.
  - Only one is asserted: grant that requester.
  - Both are asserted: grant data, unless streak == `MAX_D_STREAK`, in which case grant fetch.
  - On a grant, latch the address, `we` and `wdata`. For a fetch, `we` = 0 and `wdata` = 0. Then go to ISSUE.
  - Requester inputs are ignored after the latch.
- Streak counter:
  - Increments on a data grant while `i_req`=1, saturating at `MAX_D_STREAK`.
  - Clears on any fetch grant.
  - Clears on a data grant while `i_req`=0.
- ISSUE: `mem_req`=1, and `mem_addr`, `mem_we` and `mem_wdata` are driven from the latched values, held stable.
  - `mem_ready`=1: capture `mem_rdata` into the granted requester's rdata register and go to DONE.
  - Otherwise increment the timeout counter.
  - If `TIMEOUT`≠0 and the counter reaches `TIMEOUT`−1 with no ready: go to DONE, force rdata to 0 and set `timeout_err`.
- DONE: `mem_req`=0, the granted requester's ack is 1, and rdata is valid. Clear the timeout counter and return to IDLE.
  - The requester must drop `req` by the edge that ends the DONE cycle.
- The rdata registers hold their value after ack.
- Writes still complete through `mem_ready`, and `d_rdata` captures whatever `mem_rdata` shows at that point.
- `mem_ready` outside ISSUE is ignored.

## Timing
- Request seen in IDLE at cycle t:
  - `mem_req` rises at t+1 (registered).
  - `mem_ready` is accepted as early as t+1.
  - Ready at cycle k gives ack at k+1.
  - The arbiter is back in IDLE at k+2.
  - The next `mem_req` rises at k+3 at the earliest.
- Minimum transaction length is 3 cycles from request to ack. Throughput is one transaction per ≥3 cycles.
- On timeout, `mem_req` is high for exactly `TIMEOUT` cycles. Ack comes the following cycle, and `timeout_err` is set in the same cycle as ack.
- Ack is never asserted for both sides in the same cycle. Ack is never asserted outside DONE.

## Test plan
- **Reset values:** assert `reset_n`=0 mid-run → all outputs 0 immediately. Release, hold `i_req`=`d_req`=0 for 10 cycles → `busy`=0 and `mem_req`=0 throughout.
- **Single fetch:**
  - Stimulus: `i_req` at cycle 0 with `i_addr`=0x00400000; `mem_ready` at cycle 3 with `mem_rdata`=0x20080005.
  - Response: `mem_req`=1 during cycles 1–3 with `mem_addr`=0x00400000 and `mem_we`=0; `i_ack`=1 at cycle 4 with `i_rdata`=0x20080005; `busy`=0 at cycle 5.
- **Collision:**
  - Stimulus: at cycle 0, `i_req` (0x00400004) and a `d_req` load (0x10010000) together; memory ready 1 cycle after each `mem_req` rise.
  - Response: the data access is issued first and `d_ack` returns the load data. The fetch is issued next (`mem_req` rises at cycle 4) and `i_ack` follows.
- **Starvation bound:** hold `d_req` and `i_req` continuously with `MAX_D_STREAK`=4 → exactly 4 `d_ack` pulses, then an `i_ack`, then data grants resume.
- **Timeout:** `TIMEOUT`=8, store to 0x10010008 with data 0xCAFEF00D, `mem_ready` held at 0 → `mem_req` high for exactly 8 cycles with `mem_we`=1 and `mem_wdata`=0xCAFEF00D, then `d_ack` with `d_rdata`=0 and `timeout_err`=1. `timeout_err` stays 1 until reset.
- **Reset mid-transaction:** pull `reset_n` low during ISSUE → `mem_req` drops in the same cycle. After release, the still-asserted `i_req` is re-granted from IDLE, and the stale `mem_ready` seen before the grant is ignored.
